obs_render: RTL
===============

Name: obs_render

Overview:
Obstacle scroller/renderer that drives the obstacle sprite ROM's read interface. It owns the obstacle slots and scrolls them left once per frame. It spawns new obstacles from an internal LFSR. For each VGA pixel it produces the ROM address (o_rom_counter) and sprite type (o_obs_type), then registers the returned ROM bit as the obstacle pixel for the compositor.

Parameters:
NUM_SLOTS, 2, obstacle slots; lower index has higher draw priority
SCREEN_W, 640, active width; spawn x position
SCREEN_H, 480, active height
GROUND_Y, 400, first row below obstacle box; box top = GROUND_Y-32
MIN_GAP, 200, minimum px between the newest obstacle's left edge and SCREEN_W before the next spawn
LFSR_SEED, 16'hACE1, LFSR reset value

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_hpos  in  10  current pixel x
i_vpos  in  10  current pixel y
i_frame_tick  in  1  one-cycle pulse per frame, asserted only in vblank
i_game_run  in  1  1 = scroll and spawn enabled
i_clear  in  1  one-cycle pulse that empties all slots (game restart)
i_speed  in  4  px moved per frame tick
o_rom_counter  out  8  {rom_y, rom_x} to sprite ROM
o_obs_type  out  3  sprite type to ROM; 3'b000 = EMPTY
i_sprite_color  in  1  combinational ROM output for the current o_rom_counter/o_obs_type
o_obs_pixel  out  1  obstacle pixel on, aligned 2 cycles after i_hpos/i_vpos

Behaviour:
- Reset:
  - all slots invalid, slot x = 0, slot type = EMPTY
  - o_rom_counter = 0, o_obs_type = 0, o_obs_pixel = 0
  - LFSR = LFSR_SEED
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clk regardless of i_game_run.
- Slot state: valid, x (11-bit signed left edge), type[2:0].
- Frame update (i_frame_tick & i_game_run & !i_clear):
  - every valid slot: x <= x - i_speed.
  - if new x <= -32, the slot becomes invalid and its type becomes EMPTY in the same tick.
- Spawn (same tick, evaluated on pre-update state):
  - condition: at least one free slot AND (no valid slot OR newest spawned slot's x <= SCREEN_W-MIN_GAP).
  - target: lowest-index free slot.
  - new values: x = SCREEN_W, type = LFSR[2:0]; value 000 remaps to 001.
  - at most one spawn per tick.
  - a slot freed on this tick is not reusable until the next tick.
- i_clear: all slots invalid next cycle. Wins over a simultaneous frame tick. LFSR is unaffected.
- !i_game_run: positions frozen, no spawns. Rendering continues.
- Render stage 1, registered at cycle N+1 for pixel presented at cycle N:
  - dx = hpos - x_i, dy = vpos - (GROUND_Y-32).
  - slot i hits if valid, 0<=dx<32, 0<=dy<32, hpos<SCREEN_W, vpos<SCREEN_H.
  - the lowest-index hitting slot wins.
  - o_obs_type = winner's type, else EMPTY.
  - o_rom_counter = {dy[4:1], ~dx[4:1]}: 2x scale; ROM bit 15 is the leftmost pixel.
  - no hit -> o_rom_counter = 0.
- Render stage 2: o_obs_pixel <= i_sprite_color & (o_obs_type != EMPTY), valid at N+2. Total latency 2 cycles; the compositor delays hpos/vpos to match.
- Arithmetic: all comparisons use 11-bit signed values. hpos/vpos are zero-extended.

Decomposition:
- Shared package obs_pkg: obstacle type codes (EMPTY, CAC_3, CAC_2, CAC_THICK_1, CAC_THICK_2, CAC_THIN, BIRD_LOW, BIRD_HIGH) and the sprite size/scale constants (SPR_DIM=16, SPR_SHIFT=1). The same package is used by the sprite ROM.
- One sub-module: obs_lfsr (16-bit, seedable, free-running).
- Slot update and render pipeline stay in obs_render.

Test Plan:
1. Reset, then 3 frame ticks with game_run=1, speed=4 -> slot0 spawns at x=640 on the first tick; x=632 after the 3rd tick; slot1 stays invalid.
2. slot0 at x=100, type=CAC_3; hpos=100, vpos=368 -> after 1 cycle o_rom_counter=8'h0F, o_obs_type=3'b001; o_obs_pixel equals ROM bit[15] of row 0 (0) at +2 cycles.
3. slot0 at x=-28, speed=4, tick -> slot0 invalid and type EMPTY next cycle; pixel at hpos=0 gives o_obs_type=0, o_obs_pixel=0.
4. slot0 at x=450 -> no spawn; at x=440 -> slot1 spawns at x=640 on that tick; both slots full -> no third spawn.
5. Overlap: slot0 and slot1 both cover hpos=200 -> o_obs_type is slot0's type.
6. i_clear with i_frame_tick in the same cycle -> all slots invalid, no spawn. hpos=700 with a slot covering x range -> o_obs_type=0.

Source files
------------

// File: rtl/obs_pkg.sv
// Obstacle sprite package.
// Holds the obstacle type codes and the sprite geometry constants.
// The obstacle renderer and the obstacle sprite ROM both import it.
package obs_pkg;

    typedef enum logic [2:0] {
        EMPTY       = 3'd0,
        CAC_3       = 3'd1,
        CAC_2       = 3'd2,
        CAC_THICK_1 = 3'd3,
        CAC_THICK_2 = 3'd4,
        CAC_THIN    = 3'd5,
        BIRD_LOW    = 3'd6,
        BIRD_HIGH   = 3'd7
    } obs_type_e;

    // Sprites are stored as 16x16 bitmaps and drawn at 2x scale.
    localparam int SPR_DIM   = 16;
    localparam int SPR_SHIFT = 1;
    localparam int OBS_BOX   = SPR_DIM << SPR_SHIFT;  // on-screen box edge, 32 px

    // Random bits to a drawable type. Zero would mean "no obstacle", so it
    // is folded onto the first real sprite.
    function automatic obs_type_e lfsr_to_type(input logic [2:0] bits);
        return (bits == 3'd0) ? CAC_3 : obs_type_e'(bits);
    endfunction

endpackage

// File: rtl/obs_render_if.sv
// Sprite ROM read interface between the obstacle renderer and the ROM.
//   rom_counter  : {rom_y, rom_x} address, renderer -> ROM
//   obs_type     : sprite select, EMPTY = 0, renderer -> ROM
//   sprite_color : combinational ROM bit for the current address/type, ROM -> renderer
interface obs_render_if;
    logic [7:0] rom_counter;
    logic [2:0] obs_type;
    logic       sprite_color;

    modport master (
        output rom_counter,
        output obs_type,
        input  sprite_color
    );

    modport slave (
        input  rom_counter,
        input  obs_type,
        output sprite_color
    );
endinterface

// File: rtl/obs_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used to pick obstacle types.
// Polynomial taps 16,14,13,11 (bits 15,13,12,10), shifting towards the MSB.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset, loads SEED
//   lfsr_o : current register value
module obs_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/obs_render.sv
// Obstacle scroller and renderer.
// Owns NUM_SLOTS obstacle slots, scrolls them left on each frame tick, spawns
// new obstacles at the right screen edge, and turns each pixel position into a
// sprite ROM request. The ROM bit comes back combinationally and is registered
// as the obstacle pixel, two cycles after the pixel position was presented.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_hpos, i_vpos  : current pixel position
//   i_frame_tick    : one pulse per frame (vblank), moves/spawns when i_game_run
//   i_game_run      : enables scrolling and spawning
//   i_clear         : empties all slots, wins over a same-cycle frame tick
//   i_speed         : pixels moved per frame tick
//   rom_if          : sprite ROM address/type out, ROM bit in
//   o_obs_pixel     : obstacle pixel on
module obs_render
    import obs_pkg::*;
#(
    parameter int          NUM_SLOTS = 2,
    parameter int          SCREEN_W  = 640,
    parameter int          SCREEN_H  = 480,
    parameter int          GROUND_Y  = 400,
    parameter int          MIN_GAP   = 200,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [9:0]   i_hpos,
    input  logic [9:0]   i_vpos,
    input  logic         i_frame_tick,
    input  logic         i_game_run,
    input  logic         i_clear,
    input  logic [3:0]   i_speed,
    obs_render_if.master rom_if,
    output logic         o_obs_pixel
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    // All geometry is evaluated as 11-bit signed so slots can sit partly
    // off the left edge.
    localparam logic signed [10:0] SPAWN_X = 11'(SCREEN_W);
    localparam logic signed [10:0] GAP_X   = 11'(SCREEN_W - MIN_GAP);
    localparam logic signed [10:0] KILL_X  = 11'(-OBS_BOX);
    localparam logic signed [10:0] BOX_W   = 11'(OBS_BOX);
    localparam logic signed [10:0] BOX_TOP = 11'(GROUND_Y - OBS_BOX);
    localparam logic signed [10:0] SCR_W   = 11'(SCREEN_W);
    localparam logic signed [10:0] SCR_H   = 11'(SCREEN_H);

    // ------------------------------------------------------------------
    // Type source
    // ------------------------------------------------------------------
    logic [15:0] lfsr_w;
    logic        lfsr_unused_w;

    obs_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .lfsr_o (lfsr_w)
    );

    // Only the low three bits pick a type.
    assign lfsr_unused_w = ^lfsr_w[15:3];

    // ------------------------------------------------------------------
    // Slot state
    // ------------------------------------------------------------------
    logic               slot_valid_q [NUM_SLOTS];
    logic               slot_valid_d [NUM_SLOTS];
    logic signed [10:0] slot_x_q     [NUM_SLOTS];
    logic signed [10:0] slot_x_d     [NUM_SLOTS];
    obs_type_e          slot_type_q  [NUM_SLOTS];
    obs_type_e          slot_type_d  [NUM_SLOTS];
    logic [IDX_W-1:0]   newest_q;
    logic [IDX_W-1:0]   newest_d;

    logic signed [10:0] speed_w;
    logic signed [10:0] moved_x_w [NUM_SLOTS];
    logic               any_valid_w;
    logic               free_found_w;
    logic [IDX_W-1:0]   free_idx_w;
    logic               spawn_w;

    assign speed_w = $signed({7'd0, i_speed});

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_move
        assign moved_x_w[gi] = slot_x_q[gi] - speed_w;
    end

    // Spawn decision on pre-update state: a slot freed by this very tick is
    // still counted as occupied, so it only becomes reusable next tick.
    // Scanning downwards leaves the lowest free index in free_idx_w.
    always_comb begin
        any_valid_w  = 1'b0;
        free_found_w = 1'b0;
        free_idx_w   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_valid_q[i]) begin
                any_valid_w = 1'b1;
            end else begin
                free_found_w = 1'b1;
                free_idx_w   = IDX_W'(i);
            end
        end
        spawn_w = free_found_w && (!any_valid_w || (slot_x_q[newest_q] <= GAP_X));
    end

    always_comb begin
        newest_d = newest_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_valid_d[i] = slot_valid_q[i];
            slot_x_d[i]     = slot_x_q[i];
            slot_type_d[i]  = slot_type_q[i];
        end

        if (i_clear) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_valid_d[i] = 1'b0;
                slot_type_d[i]  = EMPTY;
            end
        end else if (i_frame_tick && i_game_run) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (slot_valid_q[i]) begin
                    slot_x_d[i] = moved_x_w[i];
                    // Box fully past the left edge: retire the slot.
                    if (moved_x_w[i] <= KILL_X) begin
                        slot_valid_d[i] = 1'b0;
                        slot_type_d[i]  = EMPTY;
                    end
                end
            end
            // The spawn target was free before the tick, so it never
            // collides with the scroll updates above.
            if (spawn_w) begin
                slot_valid_d[free_idx_w] = 1'b1;
                slot_x_d[free_idx_w]     = SPAWN_X;
                slot_type_d[free_idx_w]  = lfsr_to_type(lfsr_w[2:0]);
                newest_d                 = free_idx_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_valid_q[i] <= 1'b0;
                slot_x_q[i]     <= '0;
                slot_type_q[i]  <= EMPTY;
            end
            newest_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_valid_q[i] <= slot_valid_d[i];
                slot_x_q[i]     <= slot_x_d[i];
                slot_type_q[i]  <= slot_type_d[i];
            end
            newest_q <= newest_d;
        end
    end

    // ------------------------------------------------------------------
    // Render stage 1: hit test and ROM request
    // ------------------------------------------------------------------
    logic signed [10:0]   hpos_s;
    logic signed [10:0]   vpos_s;
    logic signed [10:0]   dy_w;
    logic signed [10:0]   dx_w [NUM_SLOTS];
    logic                 on_screen_w;
    logic                 row_hit_w;
    logic [NUM_SLOTS-1:0] hit_w;

    logic [7:0] rom_counter_q;
    logic [7:0] rom_counter_d;
    obs_type_e  obs_type_q;
    obs_type_e  obs_type_d;
    logic       obs_pixel_q;

    assign hpos_s      = $signed({1'b0, i_hpos});
    assign vpos_s      = $signed({1'b0, i_vpos});
    assign dy_w        = vpos_s - BOX_TOP;
    assign on_screen_w = (hpos_s < SCR_W) && (vpos_s < SCR_H);
    assign row_hit_w   = (dy_w >= 11'sd0) && (dy_w < BOX_W);

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_hit
        assign dx_w[gi]  = hpos_s - slot_x_q[gi];
        assign hit_w[gi] = slot_valid_q[gi] && on_screen_w && row_hit_w &&
                           (dx_w[gi] >= 11'sd0) && (dx_w[gi] < BOX_W);
    end

    // Walk from the highest index down so the lowest hitting slot wins.
    // Dropping bit 0 of dx/dy gives the 2x scale; x is inverted because the
    // ROM stores the leftmost pixel in bit 15.
    always_comb begin
        rom_counter_d = 8'd0;
        obs_type_d    = EMPTY;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit_w[i]) begin
                rom_counter_d = {dy_w[4:1], ~dx_w[i][4:1]};
                obs_type_d    = slot_type_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_counter_q <= 8'd0;
            obs_type_q    <= EMPTY;
            obs_pixel_q   <= 1'b0;
        end else begin
            rom_counter_q <= rom_counter_d;
            obs_type_q    <= obs_type_d;
            // Render stage 2: capture the ROM answer for the stage-1 request.
            obs_pixel_q   <= rom_if.sprite_color & (obs_type_q != EMPTY);
        end
    end

    assign rom_if.rom_counter = rom_counter_q;
    assign rom_if.obs_type    = obs_type_q;
    assign o_obs_pixel        = obs_pixel_q;

endmodule
